// File: rtl/mst_fifo_arbiter_pkg.sv
// Shared definitions for the master write FIFO arbiter: arbiter state
// encoding, word width and default watchdog limit.
package mst_fifo_arbiter_pkg;

    localparam int DATA_W      = 18;
    localparam int ARB_TIMEOUT = 256;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_GNT0 = 2'd1,
        ARB_GNT1 = 2'd2,
        ARB_GAP  = 2'd3
    } arb_state_t;

endpackage

// File: rtl/mst_fifo_arbiter.sv
// Round-robin arbiter sharing the PCIe master write FIFO between two TLP
// generators; the grant is held for a whole TLP, with a watchdog for stalls.
module mst_fifo_arbiter
    import mst_fifo_arbiter_pkg::*;
#(
    parameter int TIMEOUT = ARB_TIMEOUT,
    parameter int CNT_W   = 16
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              req0,
    output logic              gnt0,
    input  logic [DATA_W-1:0] din0,
    input  logic              wr_en0,
    input  logic              last0,
    output logic              full0,
    input  logic              req1,
    output logic              gnt1,
    input  logic [DATA_W-1:0] din1,
    input  logic              wr_en1,
    input  logic              last1,
    output logic              full1,
    output logic [DATA_W-1:0] mst_din,
    output logic              mst_wr_en,
    input  logic              mst_full,
    output logic [CNT_W-1:0]  tlp_cnt0,
    output logic [CNT_W-1:0]  tlp_cnt1,
    output logic              drop_err,
    output logic              tmo_err
);

    localparam int              WD_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

    arb_state_t        state_reg, state_next;
    logic              last_served_reg;
    logic [WD_W-1:0]   wdog_reg;
    logic [DATA_W-1:0] mst_din_reg;
    logic              mst_wr_en_reg;
    logic [CNT_W-1:0]  tlp_cnt0_reg, tlp_cnt1_reg;
    logic              drop_err_reg, tmo_err_reg;

    logic acc0, acc1, acc_any, acc_last, gnt_any, wdog_exp, drop_next;

    assign gnt0    = (state_reg == ARB_GNT0);
    assign gnt1    = (state_reg == ARB_GNT1);
    assign gnt_any = gnt0 | gnt1;
    assign full0   = mst_full | ~gnt0;
    assign full1   = mst_full | ~gnt1;

    // A word is taken only from the granted port while the FIFO has room;
    // every other write strobe is discarded and flagged.
    assign acc0      = wr_en0 & ~full0;
    assign acc1      = wr_en1 & ~full1;
    assign acc_any   = acc0 | acc1;
    assign acc_last  = (acc0 & last0) | (acc1 & last1);
    assign drop_next = (wr_en0 & ~acc0) | (wr_en1 & ~acc1);
    // An accepted word (including the last one) always beats expiry.
    assign wdog_exp  = gnt_any & ~acc_any & (wdog_reg == WD_MAX);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ARB_IDLE: begin
                if (req0 && req1)
                    state_next = last_served_reg ? ARB_GNT0 : ARB_GNT1;
                else if (req0)
                    state_next = ARB_GNT0;
                else if (req1)
                    state_next = ARB_GNT1;
            end
            ARB_GNT0, ARB_GNT1: begin
                if (acc_last || wdog_exp)
                    state_next = ARB_GAP;
            end
            default: state_next = ARB_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_reg       <= ARB_IDLE;
            last_served_reg <= 1'b1;
            wdog_reg        <= '0;
            mst_din_reg     <= '0;
            mst_wr_en_reg   <= 1'b0;
            tlp_cnt0_reg    <= '0;
            tlp_cnt1_reg    <= '0;
            drop_err_reg    <= 1'b0;
            tmo_err_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mst_wr_en_reg <= acc_any;
            drop_err_reg  <= drop_next;
            tmo_err_reg   <= wdog_exp;
            if (acc0)
                mst_din_reg <= din0;
            else if (acc1)
                mst_din_reg <= din1;
            // Idle granted cycles (including FIFO-full stalls) age the watchdog.
            if (gnt_any && !acc_any && !wdog_exp)
                wdog_reg <= wdog_reg + WD_W'(1);
            else
                wdog_reg <= '0;
            if (acc0 && last0) begin
                tlp_cnt0_reg    <= tlp_cnt0_reg + CNT_W'(1);
                last_served_reg <= 1'b0;
            end
            if (acc1 && last1) begin
                tlp_cnt1_reg    <= tlp_cnt1_reg + CNT_W'(1);
                last_served_reg <= 1'b1;
            end
            if (wdog_exp)
                last_served_reg <= gnt1;
        end
    end

    assign mst_din   = mst_din_reg;
    assign mst_wr_en = mst_wr_en_reg;
    assign tlp_cnt0  = tlp_cnt0_reg;
    assign tlp_cnt1  = tlp_cnt1_reg;
    assign drop_err  = drop_err_reg;
    assign tmo_err   = tmo_err_reg;

endmodule
